// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and time-field limits for the alarm stage
package alarm_pkg;
    localparam int HOUR_W = 5;
    localparam int MIN_W = 6;
    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        RINGING   = 3'd3,
        SNOOZE    = 3'd4
    } state_t;
endpackage

// File: rtl/alarm_unit_buzzer_tone_gen.sv
// buzzer_tone_gen: square wave toggling every BUZZ_DIV cycles while enabled
module buzzer_tone_gen #(
    parameter int BUZZ_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic buzzer
);
    localparam int DW = $clog2(BUZZ_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BUZZ_DIV - 1);
    logic [DW-1:0] div;
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div <= '0;
            buzzer <= 1'b0;
        end else begin
            div <= div == DIV_LAST ? '0 : div + 1'b1;
            buzzer <= div == DIV_LAST ? ~buzzer : buzzer;
        end
    end
endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: editable alarm time, trigger/ring/snooze FSM and gated buzzer
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int BUZZ_DIV = 25000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [MIN_W-1:0]  cur_sec,
    input  logic              sec_tick,
    input  logic              arm,
    input  logic              set_mode,
    input  logic              up_pulse,
    input  logic              down_pulse,
    input  logic              center_pulse,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic              ringing,
    output logic              buzzer,
    output logic [2:0]        state
);
    localparam int RW = $clog2(RING_SECONDS + 1);
    localparam int SW = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);
    state_t st, st_next;
    logic [HOUR_W-1:0] hour_next;
    logic [MIN_W-1:0] min_next;
    logic [RW-1:0] ring_cnt, ring_next;
    logic [SW-1:0] snz_cnt, snz_next;
    logic trigger, inc, dec;
    assign trigger = arm && sec_tick && cur_hour == alarm_hour && cur_min == alarm_min && cur_sec == '0;
    assign inc = up_pulse && !down_pulse;
    assign dec = down_pulse && !up_pulse;
    assign state = st;
    always_comb begin
        st_next = st;
        hour_next = alarm_hour;
        min_next = alarm_min;
        ring_next = ring_cnt;
        snz_next = snz_cnt;
        case (st)
            IDLE: begin
                if (set_mode && center_pulse) st_next = EDIT_HOUR;
                else if (trigger) begin
                    st_next = RINGING;
                    ring_next = '0;
                end
            end
            EDIT_HOUR: begin
                if (!set_mode) st_next = IDLE;
                else if (center_pulse) st_next = EDIT_MIN;
                else hour_next = inc ? (alarm_hour == MAX_HOUR ? '0 : alarm_hour + 1'b1)
                               : dec ? (alarm_hour == '0 ? MAX_HOUR : alarm_hour - 1'b1)
                               : alarm_hour;
            end
            EDIT_MIN: begin
                if (!set_mode || center_pulse) st_next = IDLE;
                else min_next = inc ? (alarm_min == MAX_MIN ? '0 : alarm_min + 1'b1)
                              : dec ? (alarm_min == '0 ? MAX_MIN : alarm_min - 1'b1)
                              : alarm_min;
            end
            RINGING: begin
                if (!arm || center_pulse) st_next = IDLE;
                else if (up_pulse || down_pulse) begin
                    st_next = SNOOZE;
                    snz_next = '0;
                end else if (sec_tick) begin
                    st_next = ring_cnt == RING_LAST ? IDLE : RINGING;
                    ring_next = ring_cnt + 1'b1;
                end
            end
            SNOOZE: begin
                if (!arm || center_pulse) st_next = IDLE;
                else if (sec_tick) begin
                    st_next = snz_cnt == SNOOZE_LAST ? RINGING : SNOOZE;
                    snz_next = snz_cnt + 1'b1;
                    ring_next = '0;
                end
            end
            default: st_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= IDLE;
            alarm_hour <= '0;
            alarm_min <= '0;
            ring_cnt <= '0;
            snz_cnt <= '0;
            ringing <= 1'b0;
        end else begin
            st <= st_next;
            alarm_hour <= hour_next;
            alarm_min <= min_next;
            ring_cnt <= ring_next;
            snz_cnt <= snz_next;
            ringing <= st_next == RINGING;
        end
    end
    // divider only runs across cycles that both start and end in RINGING
    buzzer_tone_gen #(.BUZZ_DIV(BUZZ_DIV)) u_tone (
        .clk(clk),
        .rst_n(rst_n),
        .en(st == RINGING && st_next == RINGING),
        .buzzer(buzzer)
    );
endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage of the wall clock: consumes the running hour/minute/second counts and the debounced button pulses, holds a user-editable alarm time, and drives a ringing flag plus a gated square-wave buzzer output. It sits downstream of the time counter chain and debouncers, in parallel with the BCD/seven-segment display path. The display path shows `alarm_hour`/`alarm_min` while in edit mode.

## Interface
- `RING_SECONDS`, 60: auto-silence after this many `sec_tick`s of ringing.
- `SNOOZE_SECONDS`, 300: `sec_tick`s spent in snooze before ringing resumes.
- `BUZZ_DIV`, 25000: `clk` cycles per buzzer half-period (1 kHz at 50 MHz).
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cur_hour`  in  5  current hour, 0–23.
- `cur_min`  in  6  current minute, 0–59.
- `cur_sec`  in  6  current second, 0–59.
- `sec_tick`  in  1  one-cycle pulse, asserted in the cycle the `cur_*` inputs show a new second.
- `arm`  in  1  level; alarm enabled.
- `set_mode`  in  1  level; alarm edit permitted.
- `up_pulse`, `down_pulse`, `center_pulse`  in  1 each  one-cycle debounced press pulses.
- `alarm_hour`  out  5  stored alarm hour.
- `alarm_min`  out  6  stored alarm minute.
- `ringing`  out  1  high in RINGING.
- `buzzer`  out  1  tone output; 0 outside RINGING.
- `state`  out  3  current FSM state code, for display/debug.

## Operation
- Reset (`rst_n`=0 at a clk edge) forces every register and output to 0: `alarm_hour`=0, `alarm_min`=0, `ringing`=0, `buzzer`=0, and `state`=IDLE. All counters are cleared.
- **IDLE (0)**
  - `set_mode`=1 and `center_pulse` → EDIT_HOUR.
  - Trigger: `arm`=1 and `sec_tick`=1 and `cur_hour`==`alarm_hour` and `cur_min`==`alarm_min` and `cur_sec`==0 → RINGING.
- **EDIT_HOUR (1)**
  - `up_pulse` increments `alarm_hour`, wrapping 23→0.
  - `down_pulse` decrements it, wrapping 0→23.
  - `center_pulse` → EDIT_MIN.
- **EDIT_MIN (2)**
  - `up_pulse`/`down_pulse` step `alarm_min` modulo 60.
  - `center_pulse` → IDLE.
- **Leaving edit early:** if `set_mode` falls in either edit state → IDLE; edited values are kept.
- **Triggers during edit:** a trigger condition while in an edit state is ignored and is not deferred.
- **RINGING (3)**
  - Ring counter increments on each `sec_tick`. When it reaches `RING_SECONDS` → IDLE.
  - `center_pulse` → IDLE (dismiss).
  - `up_pulse` or `down_pulse` → SNOOZE.
  - `arm`=0 → IDLE.
- **SNOOZE (4)**
  - Snooze counter increments on each `sec_tick`. When it reaches `SNOOZE_SECONDS` → RINGING, with the ring counter and buzzer divider cleared.
  - `center_pulse` or `arm`=0 → IDLE.
- **Priority**
  - Within a cycle: `arm`=0 beats `center_pulse`, which beats `up_pulse`/`down_pulse`, which beat counter expiry.
  - In edit states, `up_pulse` and `down_pulse` in the same cycle produce no change.
- **Buzzer**
  - The divider runs only in RINGING and is cleared on entry.
  - `buzzer` toggles each time the divider reaches `BUZZ_DIV`−1.
  - `buzzer` is forced to 0 in every other state.
- **Codes:** states 5–7 are unused and recover to IDLE.

## Timing
- All outputs are registered. Every state transition and every alarm-field change is visible the cycle after the causing input.
- Trigger latency: `ringing` rises 1 cycle after the matching `sec_tick`.
- First `buzzer` rise: `BUZZ_DIV` cycles after `ringing` rises. Steady-state period: 2·`BUZZ_DIV` cycles.
- Auto-silence: `ringing` falls 1 cycle after the `RING_SECONDS`-th `sec_tick` counted in RINGING.
- Snooze: ringing resumes 1 cycle after the `SNOOZE_SECONDS`-th `sec_tick` counted in SNOOZE.
- Reset mid-ring: `ringing` and `buzzer` are 0 from the first edge with `rst_n`=0.

## Structure
- Package `alarm_pkg`:
  - state encoding (IDLE..SNOOZE);
  - `MAX_HOUR`=23 and `MAX_MIN`=59;
  - hour/minute width constants, shared with the time counters.
- Sub-module `buzzer_tone_gen`: parameter `BUZZ_DIV`; inputs `clk`, `rst_n`, enable; output registered `buzzer`. Clearing the enable clears the divider and the output.
- The top of the block contains the FSM, the alarm registers, and the ring/snooze second counters.

## Test plan
- Reset with `arm`=1 and `cur_*`=00:00:00, then a `sec_tick` → `ringing`=1 one cycle later (alarm 00:00 matches).
- From IDLE with `set_mode`=1: center, 3× down, center, 2× up, center → `alarm_hour`=21, `alarm_min`=2, state back to IDLE.
- Alarm 07:30, `arm`=1, drive `cur_*`=07:30:00 with `sec_tick` → RINGING. 60 further ticks → `ringing` falls 1 cycle after the 60th. `buzzer` period is 2·`BUZZ_DIV` throughout.
- Ringing, then `up_pulse` → SNOOZE with `buzzer`=0. 300 ticks → RINGING again. Then `center_pulse` and `up_pulse` in the same cycle → IDLE.
- While in EDIT_MIN, present a matching time with `sec_tick` → no ringing. `set_mode` low → IDLE with edits retained.
- Ringing, then `arm` dropped in the same cycle as `center_pulse` → IDLE. Assert `rst_n`=0 mid-ring → all outputs 0 on the next edge.
